interrupt_sequencer: RTL and testbench
======================================

INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

Interface
REQ-001 SHALL have exactly one clock and one reset; reset is asynchronous and active-low.
REQ-002 clk  input  1  system clock; all state changes on posedge.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 softInt  input  1  software interrupt request from the decoder; active-low; valid when sampled at posedge.
REQ-005 softIndex  input  4  software interrupt number; meaningful only while softInt=0.
REQ-006 eret  input  1  return-from-interrupt from the decoder; active-low.
REQ-007 extReq  input  4  external request levels; active-high; bit 0 has highest priority.
REQ-008 ihEnable  input  1  global external-interrupt enable (IH bit 15); does not mask softInt.
REQ-009 pcCurrent  input  16  PC of the instruction to resume after service.
REQ-010 stall  output  1  freezes fetch/decode while high.
REQ-011 flush  output  1  one-cycle pipeline flush pulse.
REQ-012 pcLoad  output  1  one-cycle PC overwrite strobe.
REQ-013 pcTarget  output  16  PC value applied when pcLoad=1.
REQ-014 epc  output  16  saved return PC.
REQ-015 cause  output  4  saved interrupt cause.
REQ-016 inService  output  1  high while a handler runs.
REQ-017 extAck  output  4  one-hot, one-cycle acknowledge to the accepted external source.
REQ-018 lostInt  output  1  sticky flag: a request arrived that could not be taken.

Function
REQ-019 SHALL implement states IDLE, FLUSH, VECTOR, SERVICE, RETURN; all outputs registered.
REQ-020 IDLE: softInt=0 at posedge -> FLUSH; softInt takes priority over any external request.
REQ-021 IDLE: softInt=1, ihEnable=1 and extReq!=0 -> FLUSH, accepting the lowest set bit i.
REQ-022 On acceptance edge: epc<=pcCurrent; cause<=softIndex (software) or {2'b11,i[1:0]} (external).
REQ-023 FLUSH (one cycle): flush=1, stall=1, extAck[i]=1 if external; else extAck=0 -> VECTOR.
REQ-024 VECTOR (one cycle): pcLoad=1, pcTarget=16'h0008, stall=1 -> SERVICE.
REQ-025 SERVICE: inService=1, stall=0; remains until eret=0 at posedge -> RETURN.
REQ-026 RETURN (one cycle): pcLoad=1, pcTarget=epc, flush=1, stall=1 -> IDLE.
REQ-027 Latency: request accepted at edge N -> flush during cycle N+1, pcLoad(0x0008) during N+2, inService from N+3.
REQ-028 Return latency: eret sampled at edge M -> pcLoad(epc) during M+1, IDLE and inService=0 from M+2.
REQ-029 softInt=0 in any state other than IDLE SHALL be dropped and set lostInt=1; epc/cause unchanged.
REQ-030 External requests in non-IDLE states are not dropped (level-held), are not flagged, and are reconsidered in IDLE.
REQ-031 Simultaneous eret=0 and softInt=0 in SERVICE: eret wins -> RETURN; lostInt=1.
REQ-032 eret=0 outside SERVICE SHALL be ignored with no output change.
REQ-033 ihEnable=0 in IDLE with extReq!=0: no acceptance, no lostInt.
REQ-034 pcTarget SHALL hold its last driven value when pcLoad=0; flush, pcLoad and extAck are 0 in every state not listed above.

Reset
REQ-035 rst=0 SHALL immediately force IDLE, stall=0, flush=0, pcLoad=0, pcTarget=0, epc=0, cause=0, inService=0, extAck=0, lostInt=0, including mid-sequence.
REQ-036 After rst rises, the first posedge SHALL evaluate requests per REQ-020/021.

Verification
REQ-037 softInt=0, softIndex=4'h5, pcCurrent=16'h0123 at edge N -> flush cycle N+1, pcLoad with pcTarget=16'h0008 cycle N+2, epc=16'h0123, cause=4'h5, inService=1 from N+3.
REQ-038 extReq=4'b0110, ihEnable=1, pcCurrent=16'h0040 -> extAck=4'b0010 during FLUSH, cause=4'hD; then eret=0 -> one-cycle pcLoad with pcTarget=16'h0040, then IDLE.
REQ-039 extReq=4'b0001 and softInt=0 on same edge -> software accepted, cause=softIndex, extAck=0; after eret, external accepted with cause=4'hC.
REQ-040 In SERVICE drive softInt=0 and eret=0 on same edge -> RETURN taken, lostInt=1 and remains 1 until reset.
REQ-041 ihEnable=0, extReq=4'b1111 for 10 cycles -> state stays IDLE, all outputs 0; set ihEnable=1 -> accept bit 0, cause=4'hC.
REQ-042 Assert rst=0 during VECTOR -> all outputs 0 asynchronously, no pcLoad; after release with no requests, state remains IDLE.

Source files
------------

// File: rtl/interrupt_sequencer.sv
// Interrupt entry/exit sequencer: accepts one software or external request from
// IDLE, walks FLUSH -> VECTOR -> SERVICE -> RETURN, and drives registered pipeline controls.
module interrupt_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        softInt,
  input  logic [3:0]  softIndex,
  input  logic        eret,
  input  logic [3:0]  extReq,
  input  logic        ihEnable,
  input  logic [15:0] pcCurrent,
  output logic        stall,
  output logic        flush,
  output logic        pcLoad,
  output logic [15:0] pcTarget,
  output logic [15:0] epc,
  output logic [3:0]  cause,
  output logic        inService,
  output logic [3:0]  extAck,
  output logic        lostInt,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FLUSH   = 3'd1,
    S_VECTOR  = 3'd2,
    S_SERVICE = 3'd3,
    S_RETURN  = 3'd4
  } state_e;

  localparam logic [15:0] VECTOR_ADDR = 16'h0008;

  state_e      state_q, state_d;
  logic        stall_q, stall_d;
  logic        flush_q, flush_d;
  logic        pc_load_q, pc_load_d;
  logic [15:0] pc_target_q, pc_target_d;
  logic [15:0] epc_q, epc_d;
  logic [3:0]  cause_q, cause_d;
  logic        in_service_q, in_service_d;
  logic [3:0]  ext_ack_q, ext_ack_d;
  logic        lost_int_q, lost_int_d;

  logic        soft_req;
  logic        ext_take;
  logic [1:0]  ext_idx;
  logic [3:0]  ext_onehot;

  // Lowest set request bit wins; the one-hot form becomes the acknowledge.
  always_comb begin
    ext_idx    = 2'd0;
    ext_onehot = 4'b0000;
    if (extReq[0]) begin
      ext_idx    = 2'd0;
      ext_onehot = 4'b0001;
    end else if (extReq[1]) begin
      ext_idx    = 2'd1;
      ext_onehot = 4'b0010;
    end else if (extReq[2]) begin
      ext_idx    = 2'd2;
      ext_onehot = 4'b0100;
    end else if (extReq[3]) begin
      ext_idx    = 2'd3;
      ext_onehot = 4'b1000;
    end
  end

  assign soft_req = ~softInt;
  assign ext_take = ihEnable && (extReq != 4'b0000);

  always_comb begin
    state_d    = state_q;
    epc_d      = epc_q;
    cause_d    = cause_q;
    lost_int_d = lost_int_q;
    ext_ack_d  = 4'b0000;

    case (state_q)
      S_IDLE: begin
        if (soft_req) begin
          state_d = S_FLUSH;
          epc_d   = pcCurrent;
          cause_d = softIndex;
        end else if (ext_take) begin
          state_d   = S_FLUSH;
          epc_d     = pcCurrent;
          cause_d   = {2'b11, ext_idx};
          ext_ack_d = ext_onehot;
        end
      end
      S_FLUSH: begin
        state_d = S_VECTOR;
        if (soft_req) lost_int_d = 1'b1;
      end
      S_VECTOR: begin
        state_d = S_SERVICE;
        if (soft_req) lost_int_d = 1'b1;
      end
      S_SERVICE: begin
        // A software request colliding with eret is dropped; the return proceeds.
        if (!eret) state_d = S_RETURN;
        if (soft_req) lost_int_d = 1'b1;
      end
      S_RETURN: begin
        state_d = S_IDLE;
        if (soft_req) lost_int_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they appear registered in that state's cycle.
  always_comb begin
    stall_d      = 1'b0;
    flush_d      = 1'b0;
    pc_load_d    = 1'b0;
    in_service_d = 1'b0;
    pc_target_d  = pc_target_q;
    case (state_d)
      S_FLUSH: begin
        stall_d = 1'b1;
        flush_d = 1'b1;
      end
      S_VECTOR: begin
        stall_d     = 1'b1;
        pc_load_d   = 1'b1;
        pc_target_d = VECTOR_ADDR;
      end
      S_SERVICE: begin
        in_service_d = 1'b1;
      end
      S_RETURN: begin
        stall_d     = 1'b1;
        flush_d     = 1'b1;
        pc_load_d   = 1'b1;
        pc_target_d = epc_q;
      end
      default: begin
        stall_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      stall_q      <= 1'b0;
      flush_q      <= 1'b0;
      pc_load_q    <= 1'b0;
      pc_target_q  <= 16'h0000;
      epc_q        <= 16'h0000;
      cause_q      <= 4'h0;
      in_service_q <= 1'b0;
      ext_ack_q    <= 4'b0000;
      lost_int_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      stall_q      <= stall_d;
      flush_q      <= flush_d;
      pc_load_q    <= pc_load_d;
      pc_target_q  <= pc_target_d;
      epc_q        <= epc_d;
      cause_q      <= cause_d;
      in_service_q <= in_service_d;
      ext_ack_q    <= ext_ack_d;
      lost_int_q   <= lost_int_d;
    end
  end

  assign stall     = stall_q;
  assign flush     = flush_q;
  assign pcLoad    = pc_load_q;
  assign pcTarget  = pc_target_q;
  assign epc       = epc_q;
  assign cause     = cause_q;
  assign inService = in_service_q;
  assign extAck    = ext_ack_q;
  assign lostInt   = lost_int_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: inputs change on negedge, outputs are
// sampled on the following negedge, one task per scenario.
module tb_interrupt_sequencer;

  logic        clk;
  logic        rst;
  logic        softInt;
  logic [3:0]  softIndex;
  logic        eret;
  logic [3:0]  extReq;
  logic        ihEnable;
  logic [15:0] pcCurrent;
  logic        stall;
  logic        flush;
  logic        pcLoad;
  logic [15:0] pcTarget;
  logic [15:0] epc;
  logic [3:0]  cause;
  logic        inService;
  logic [3:0]  extAck;
  logic        lostInt;
  logic [2:0]  dbg_state;

  int tests_run;
  int tests_failed;

  // {stall, flush, pcLoad, lostInt, extAck, pcTarget, epc, cause}
  logic [43:0] obs;
  logic [43:0] exp_v;
  assign obs = {stall, flush, pcLoad, lostInt, extAck, pcTarget, epc, cause};

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SERVICE = 3'd3;

  interrupt_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .softInt   (softInt),
    .softIndex (softIndex),
    .eret      (eret),
    .extReq    (extReq),
    .ihEnable  (ihEnable),
    .pcCurrent (pcCurrent),
    .stall     (stall),
    .flush     (flush),
    .pcLoad    (pcLoad),
    .pcTarget  (pcTarget),
    .epc       (epc),
    .cause     (cause),
    .inService (inService),
    .extAck    (extAck),
    .lostInt   (lostInt),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; softInt = 1'b1; softIndex = 4'h0; eret = 1'b1;
    extReq = 4'b0000; ihEnable = 1'b0; pcCurrent = 16'h0000;
    #1;
    exp_v = 44'h0;
    tests_run++;
    if (obs !== exp_v) begin tests_failed++; $display("FAIL reset_outputs: got %h want %h", obs, exp_v); end
    tests_run++;
    if (inService !== 1'b0) begin tests_failed++; $display("FAIL reset_insvc: got %b want 0", inService); end
    @(negedge clk);
    rst = 1'b1;
    tick();
    tests_run++;
    if (dbg_state !== ST_IDLE || obs !== 44'h0) begin
      tests_failed++; $display("FAIL reset_idle: state %0d obs %h want 0/0", dbg_state, obs);
    end
  endtask

  task automatic test_soft_path();
    softInt = 1'b0; softIndex = 4'h5; pcCurrent = 16'h0123;
    tick();
    softInt = 1'b1;
    exp_v = {1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 16'h0000, 16'h0123, 4'h5};
    tests_run++;
    if (obs !== exp_v) begin tests_failed++; $display("FAIL soft_flush: got %h want %h", obs, exp_v); end
    tick();
    exp_v = {1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 16'h0008, 16'h0123, 4'h5};
    tests_run++;
    if (obs !== exp_v) begin tests_failed++; $display("FAIL soft_vector: got %h want %h", obs, exp_v); end
    tick();
    exp_v = {1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 16'h0008, 16'h0123, 4'h5};
    tests_run++;
    if (obs !== exp_v || inService !== 1'b1) begin
      tests_failed++; $display("FAIL soft_service: got %h insvc %b want %h insvc 1", obs, inService, exp_v);
    end
    tick();
    tests_run++;
    if (inService !== 1'b1 || dbg_state !== ST_SERVICE) begin
      tests_failed++; $display("FAIL soft_service_hold: insvc %b state %0d want 1/3", inService, dbg_state);
    end
    eret = 1'b0;
    tick();
    eret = 1'b1;
    exp_v = {1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 16'h0123, 16'h0123, 4'h5};
    tests_run++;
    if (obs !== exp_v) begin tests_failed++; $display("FAIL soft_return: got %h want %h", obs, exp_v); end
    tick();
    exp_v = {1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 16'h0123, 16'h0123, 4'h5};
    tests_run++;
    if (obs !== exp_v || inService !== 1'b0 || dbg_state !== ST_IDLE) begin
      tests_failed++; $display("FAIL soft_back_idle: got %h insvc %b state %0d want %h 0 0", obs, inService, dbg_state, exp_v);
    end
  endtask

  task automatic test_ext_path();
    ihEnable = 1'b1; extReq = 4'b0110; pcCurrent = 16'h0040;
    tick();
    extReq = 4'b0000;
    exp_v = {1'b1, 1'b1, 1'b0, 1'b0, 4'b0010, 16'h0123, 16'h0040, 4'hD};
    tests_run++;
    if (obs !== exp_v) begin tests_failed++; $display("FAIL ext_flush: got %h want %h", obs, exp_v); end
    tick();
    exp_v = {1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 16'h0008, 16'h0040, 4'hD};
    tests_run++;
    if (obs !== exp_v) begin tests_failed++; $display("FAIL ext_vector: got %h want %h", obs, exp_v); end
    tick();
    eret = 1'b0;
    tick();
    eret = 1'b1;
    exp_v = {1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 16'h0040, 16'h0040, 4'hD};
    tests_run++;
    if (obs !== exp_v) begin tests_failed++; $display("FAIL ext_return: got %h want %h", obs, exp_v); end
    tick();
    tick();
    exp_v = {1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 16'h0040, 16'h0040, 4'hD};
    tests_run++;
    if (obs !== exp_v || dbg_state !== ST_IDLE) begin
      tests_failed++; $display("FAIL ext_idle: got %h state %0d want %h 0", obs, dbg_state, exp_v);
    end
  endtask

  task automatic test_soft_over_ext();
    softInt = 1'b0; softIndex = 4'h9; extReq = 4'b0001; pcCurrent = 16'h0100;
    tick();
    softInt = 1'b1;
    exp_v = {1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 16'h0040, 16'h0100, 4'h9};
    tests_run++;
    if (obs !== exp_v) begin tests_failed++; $display("FAIL prio_flush: got %h want %h", obs, exp_v); end
    tick();
    tick();
    eret = 1'b0; pcCurrent = 16'h0200;
    tick();
    eret = 1'b1;
    exp_v = {1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 16'h0100, 16'h0100, 4'h9};
    tests_run++;
    if (obs !== exp_v) begin tests_failed++; $display("FAIL prio_return: got %h want %h", obs, exp_v); end
    tick();
    exp_v = {1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 16'h0100, 16'h0100, 4'h9};
    tests_run++;
    if (obs !== exp_v || dbg_state !== ST_IDLE) begin
      tests_failed++; $display("FAIL prio_idle: got %h state %0d want %h 0", obs, dbg_state, exp_v);
    end
    tick();
    extReq = 4'b0000;
    exp_v = {1'b1, 1'b1, 1'b0, 1'b0, 4'b0001, 16'h0100, 16'h0200, 4'hC};
    tests_run++;
    if (obs !== exp_v) begin tests_failed++; $display("FAIL held_ext_flush: got %h want %h", obs, exp_v); end
    tick();
    tick();
    eret = 1'b0;
    tick();
    eret = 1'b1;
    tick();
    tests_run++;
    if (dbg_state !== ST_IDLE || lostInt !== 1'b0) begin
      tests_failed++; $display("FAIL held_ext_done: state %0d lost %b want 0/0", dbg_state, lostInt);
    end
  endtask

  task automatic test_lost_int();
    softInt = 1'b0; softIndex = 4'h3; pcCurrent = 16'h0300;
    tick();
    softInt = 1'b1;
    tick();
    tick();
    softInt = 1'b0; softIndex = 4'hA; eret = 1'b0; pcCurrent = 16'h0999;
    tick();
    softInt = 1'b1; eret = 1'b1;
    exp_v = {1'b1, 1'b1, 1'b1, 1'b1, 4'b0000, 16'h0300, 16'h0300, 4'h3};
    tests_run++;
    if (obs !== exp_v) begin tests_failed++; $display("FAIL lost_collide: got %h want %h", obs, exp_v); end
    tick();
    exp_v = {1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 16'h0300, 16'h0300, 4'h3};
    tests_run++;
    if (obs !== exp_v || dbg_state !== ST_IDLE) begin
      tests_failed++; $display("FAIL lost_idle: got %h state %0d want %h 0", obs, dbg_state, exp_v);
    end
    eret = 1'b0;
    tick();
    tick();
    eret = 1'b1;
    tests_run++;
    if (obs !== exp_v || dbg_state !== ST_IDLE) begin
      tests_failed++; $display("FAIL eret_ignored: got %h state %0d want %h 0", obs, dbg_state, exp_v);
    end
  endtask

  task automatic test_ihenable_mask();
    @(negedge clk);
    rst = 1'b0;
    #2;
    rst = 1'b1;
    tick();
    ihEnable = 1'b0; extReq = 4'b1111; pcCurrent = 16'h0500;
    for (int i = 0; i < 10; i++) begin
      tick();
      tests_run++;
      if (obs !== 44'h0 || inService !== 1'b0 || dbg_state !== ST_IDLE) begin
        tests_failed++; $display("FAIL mask_cycle%0d: got %h insvc %b state %0d want 0", i, obs, inService, dbg_state);
      end
    end
    ihEnable = 1'b1;
    tick();
    extReq = 4'b0000;
    exp_v = {1'b1, 1'b1, 1'b0, 1'b0, 4'b0001, 16'h0000, 16'h0500, 4'hC};
    tests_run++;
    if (obs !== exp_v) begin tests_failed++; $display("FAIL mask_accept: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_reset_mid();
    tick();
    tests_run++;
    if (pcLoad !== 1'b1 || pcTarget !== 16'h0008) begin
      tests_failed++; $display("FAIL mid_vector: pcLoad %b pcTarget %h want 1 0008", pcLoad, pcTarget);
    end
    #2;
    rst = 1'b0;
    #1;
    tests_run++;
    if (obs !== 44'h0 || inService !== 1'b0 || dbg_state !== ST_IDLE) begin
      tests_failed++; $display("FAIL mid_async: got %h insvc %b state %0d want 0", obs, inService, dbg_state);
    end
    tick();
    tests_run++;
    if (obs !== 44'h0) begin tests_failed++; $display("FAIL mid_held: got %h want 0", obs); end
    rst = 1'b1;
    tick();
    tick();
    tests_run++;
    if (obs !== 44'h0 || dbg_state !== ST_IDLE) begin
      tests_failed++; $display("FAIL mid_release: got %h state %0d want 0", obs, dbg_state);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_soft_path();
    test_ext_path();
    test_soft_over_ext();
    test_lost_int();
    test_ihenable_mask();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
